// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-client (dcache/icache) memory arbiter.
// Holds FSM encodings, grant IDs and the default cache-side bus widths.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic GNT_D = 1'b0;
    localparam logic GNT_I = 1'b1;

    localparam int CACHE_DATABITS  = 32;
    localparam int CACHE_ADDRBITS  = 32;
    localparam int CACHE_BURSTBITS = 16;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one burst memory port between dcache and icache.
// A grant holds for a whole burst; the mem side burst length is passed through live.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DATABITS  = CACHE_DATABITS,
    parameter int ADDRBITS  = CACHE_ADDRBITS,
    parameter int BURSTBITS = CACHE_BURSTBITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDRBITS-1:0]  d_addr,
    input  logic [DATABITS-1:0]  d_in,
    output logic [DATABITS-1:0]  d_out,
    output logic                 d_valid,
    output logic [BURSTBITS-1:0] d_burstlen,
    input  logic                 d_rdreq,
    input  logic                 d_wrreq,
    output logic                 d_done,
    input  logic [ADDRBITS-1:0]  i_addr,
    input  logic [DATABITS-1:0]  i_in,
    output logic [DATABITS-1:0]  i_out,
    output logic                 i_valid,
    output logic [BURSTBITS-1:0] i_burstlen,
    input  logic                 i_rdreq,
    input  logic                 i_wrreq,
    output logic                 i_done,
    output logic [ADDRBITS-1:0]  mem_addr,
    output logic [DATABITS-1:0]  mem_in,
    input  logic [DATABITS-1:0]  mem_out,
    input  logic                 mem_valid,
    input  logic [BURSTBITS-1:0] mem_burstlen,
    output logic                 mem_rdreq,
    output logic                 mem_wrreq
);

    state_t                 state_reg, state_next;
    logic                   grant_reg, grant_next;
    logic                   write_reg, write_next;
    logic                   last_grant_reg, last_grant_next;
    logic [BURSTBITS-1:0]   count_reg, count_next;

    logic                   pend_d, pend_i, last_beat;
    logic [BURSTBITS-1:0]   last_idx;

    assign pend_d   = d_rdreq | d_wrreq;
    assign pend_i   = i_rdreq | i_wrreq;
    assign last_idx = mem_burstlen - {{(BURSTBITS-1){1'b0}}, 1'b1};
    // A zero burst length is treated as a single-beat burst.
    assign last_beat = (mem_burstlen == '0) || (count_reg == last_idx);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            grant_reg      <= GNT_D;
            write_reg      <= 1'b0;
            last_grant_reg <= GNT_I;
            count_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            write_reg      <= write_next;
            last_grant_reg <= last_grant_next;
            count_reg      <= count_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        write_next      = write_reg;
        last_grant_next = last_grant_reg;
        count_next      = count_reg;
        case (state_reg)
            IDLE: begin
                if (pend_d || pend_i) begin
                    if (pend_d && pend_i)
                        grant_next = ~last_grant_reg;
                    else
                        grant_next = pend_i ? GNT_I : GNT_D;
                    // Write wins when a client asserts both requests.
                    write_next      = (grant_next == GNT_I) ? i_wrreq : d_wrreq;
                    last_grant_next = grant_next;
                    count_next      = '0;
                    state_next      = BUSY;
                end
            end
            BUSY: begin
                if (mem_valid) begin
                    count_next = count_reg + {{(BURSTBITS-1){1'b0}}, 1'b1};
                    if (last_beat)
                        state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        d_out      = '0;
        d_valid    = 1'b0;
        d_done     = 1'b0;
        i_out      = '0;
        i_valid    = 1'b0;
        i_done     = 1'b0;
        mem_addr   = '0;
        mem_in     = '0;
        mem_rdreq  = 1'b0;
        mem_wrreq  = 1'b0;
        d_burstlen = mem_burstlen;
        i_burstlen = mem_burstlen;
        if (state_reg == BUSY && !reset) begin
            mem_rdreq = ~write_reg;
            mem_wrreq = write_reg;
            if (grant_reg == GNT_I) begin
                mem_addr = i_addr;
                mem_in   = i_in;
                i_out    = mem_out;
                i_valid  = mem_valid;
                i_done   = mem_valid & last_beat;
            end else begin
                mem_addr = d_addr;
                mem_in   = d_in;
                d_out    = mem_out;
                d_valid  = mem_valid;
                d_done   = mem_valid & last_beat;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected grants are queued when requests are
// raised and popped when the memory request appears; beats are checked live.
module tb_mem_arbiter;

    logic        clk, reset;
    logic [31:0] d_addr, d_in, d_out, i_addr, i_in, i_out;
    logic [31:0] mem_addr, mem_in, mem_out;
    logic [15:0] d_burstlen, i_burstlen, mem_burstlen;
    logic        d_valid, d_rdreq, d_wrreq, d_done;
    logic        i_valid, i_rdreq, i_wrreq, i_done;
    logic        mem_valid, mem_rdreq, mem_wrreq;

    typedef struct {
        bit          cli;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .d_addr(d_addr), .d_in(d_in), .d_out(d_out), .d_valid(d_valid),
        .d_burstlen(d_burstlen), .d_rdreq(d_rdreq), .d_wrreq(d_wrreq), .d_done(d_done),
        .i_addr(i_addr), .i_in(i_in), .i_out(i_out), .i_valid(i_valid),
        .i_burstlen(i_burstlen), .i_rdreq(i_rdreq), .i_wrreq(i_wrreq), .i_done(i_done),
        .mem_addr(mem_addr), .mem_in(mem_in), .mem_out(mem_out), .mem_valid(mem_valid),
        .mem_burstlen(mem_burstlen), .mem_rdreq(mem_rdreq), .mem_wrreq(mem_wrreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input bit cli, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata);
        txn_t t;
        t.cli = cli; t.wr = wr; t.addr = addr; t.wdata = wdata;
        exp_q.push_back(t);
    endtask

    task automatic await_grant(output txn_t t, output int waited);
        bit found = 0;
        waited = 0;
        t.cli = 0; t.wr = 0; t.addr = '0; t.wdata = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            waited++;
            #1;
            if (mem_rdreq || mem_wrreq) begin
                found = 1;
                break;
            end
        end
        chk("grant_seen", {31'd0, found}, 32'd1);
        if (exp_q.size() == 0) begin
            chk("queue_nonempty", 32'd0, 32'd1);
        end else begin
            t = exp_q.pop_front();
            chk("grant_wrreq", {31'd0, mem_wrreq}, {31'd0, t.wr});
            chk("grant_rdreq", {31'd0, mem_rdreq}, {31'd0, !t.wr});
            chk("grant_addr", mem_addr, t.addr);
            if (t.wr) chk("grant_wdata", mem_in, t.wdata);
        end
        $display("grant: cli=%0d wr=%0d addr=%0h after %0d cycles", t.cli, t.wr, t.addr, waited);
    endtask

    task automatic burst(input txn_t t, input int beats, input int gap, input bit done_last);
        logic gv, gd, ov, od;
        logic [31:0] gout;
        for (int k = 0; k < beats; k++) begin
            for (int g = 0; g < gap; g++) begin
                mem_valid = 1'b0;
                #1;
                chk("gap_d_valid", {31'd0, d_valid}, 32'd0);
                chk("gap_i_valid", {31'd0, i_valid}, 32'd0);
                @(negedge clk);
            end
            mem_valid = 1'b1;
            mem_out   = $urandom;
            #1;
            gv   = t.cli ? i_valid : d_valid;
            gd   = t.cli ? i_done  : d_done;
            gout = t.cli ? i_out   : d_out;
            ov   = t.cli ? d_valid : i_valid;
            od   = t.cli ? d_done  : i_done;
            chk("beat_valid", {31'd0, gv}, 32'd1);
            chk("beat_out", gout, mem_out);
            chk("other_valid", {31'd0, ov}, 32'd0);
            chk("other_done", {31'd0, od}, 32'd0);
            chk("beat_done", {31'd0, gd}, {31'd0, (done_last && k == beats - 1)});
            chk("req_hold", {31'd0, (t.wr ? mem_wrreq : mem_rdreq)}, 32'd1);
            chk("burstlen_pass", {16'd0, d_burstlen}, {16'd0, mem_burstlen});
            $display("beat %0d: cli=%0d data=%0h done=%0d", k, t.cli, gout, gd);
            @(negedge clk);
            mem_valid = 1'b0;
        end
    endtask

    txn_t t;
    int   w;

    initial begin
        reset = 1'b1;
        d_addr = '0; d_in = '0; d_rdreq = 0; d_wrreq = 0;
        i_addr = '0; i_in = '0; i_rdreq = 0; i_wrreq = 0;
        mem_out = '0; mem_valid = 0; mem_burstlen = '0;
        repeat (3) @(negedge clk);

        // Reset: everything zero except the burst length pass-through.
        mem_valid = 1; mem_burstlen = 16'd5; d_rdreq = 1; mem_out = 32'h1234; d_addr = 32'h44;
        #1;
        chk("rst_rdreq", {31'd0, mem_rdreq}, 32'd0);
        chk("rst_wrreq", {31'd0, mem_wrreq}, 32'd0);
        chk("rst_d_valid", {31'd0, d_valid}, 32'd0);
        chk("rst_d_out", d_out, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_d_burstlen", {16'd0, d_burstlen}, 32'd5);
        chk("rst_i_burstlen", {16'd0, i_burstlen}, 32'd5);
        @(negedge clk);
        reset = 0; d_rdreq = 0; mem_valid = 0;
        @(negedge clk);

        // dcache read, 4 beats back to back.
        d_addr = 32'h100; d_rdreq = 1; mem_burstlen = 16'd4;
        push(0, 0, 32'h100, 32'h0);
        #1;
        chk("t1_pre_req", {31'd0, mem_rdreq}, 32'd0);
        await_grant(t, w);
        chk("t1_latency", w, 32'd1);
        burst(t, 4, 0, 1);
        d_rdreq = 0;
        #1;
        chk("t1_done_state_rd", {31'd0, mem_rdreq}, 32'd0);
        @(negedge clk);
        #1;
        chk("t1_idle_rd", {31'd0, mem_rdreq}, 32'd0);

        // Simultaneous requests twice: round-robin starting from dcache.
        reset = 1;
        @(negedge clk);
        reset = 0;
        mem_burstlen = 16'd2;
        for (int r = 0; r < 2; r++) begin
            d_addr = 32'h200 + r; i_addr = 32'h300 + r;
            d_rdreq = 1; i_rdreq = 1;
            push(0, 0, 32'h200 + r, 32'h0);
            push(1, 0, 32'h300 + r, 32'h0);
            await_grant(t, w);
            burst(t, 2, 0, 1);
            d_rdreq = 0;
            await_grant(t, w);
            chk("rr_second_wait", w, 32'd2);
            burst(t, 2, 0, 1);
            i_rdreq = 0;
            @(negedge clk);
        end

        // Read+write together: write first, then the read.
        d_addr = 32'h400; d_in = 32'hdeadbeef; d_wrreq = 1; d_rdreq = 1;
        push(0, 1, 32'h400, 32'hdeadbeef);
        await_grant(t, w);
        burst(t, 2, 0, 1);
        d_wrreq = 0;
        push(0, 0, 32'h400, 32'h0);
        #1;
        chk("wr_done_state", {31'd0, mem_wrreq | mem_rdreq}, 32'd0);
        await_grant(t, w);
        chk("wr_then_rd_wait", w, 32'd2);
        burst(t, 2, 0, 1);
        d_rdreq = 0;
        @(negedge clk);

        // Zero burst length behaves as a single beat.
        mem_burstlen = 16'd0; d_addr = 32'h500; d_rdreq = 1;
        push(0, 0, 32'h500, 32'h0);
        await_grant(t, w);
        burst(t, 1, 0, 1);
        d_rdreq = 0;
        #1;
        chk("bl0_done_state", {31'd0, mem_rdreq}, 32'd0);
        @(negedge clk);
        #1;
        chk("bl0_idle", {31'd0, mem_rdreq | mem_wrreq}, 32'd0);
        mem_burstlen = 16'd1; i_addr = 32'h600; i_rdreq = 1;
        push(1, 0, 32'h600, 32'h0);
        await_grant(t, w);
        chk("bl0_back_idle", w, 32'd1);
        burst(t, 1, 0, 1);
        i_rdreq = 0;
        @(negedge clk);

        // Reset mid-burst aborts without done; dcache wins afterwards.
        mem_burstlen = 16'd8; d_addr = 32'h700; d_rdreq = 1;
        push(0, 0, 32'h700, 32'h0);
        await_grant(t, w);
        burst(t, 2, 0, 0);
        reset = 1; mem_valid = 1;
        #1;
        chk("abort_d_valid", {31'd0, d_valid}, 32'd0);
        chk("abort_d_done", {31'd0, d_done}, 32'd0);
        chk("abort_rdreq", {31'd0, mem_rdreq}, 32'd0);
        @(negedge clk);
        reset = 0; mem_valid = 0; mem_burstlen = 16'd1;
        i_addr = 32'h800; i_rdreq = 1;
        #1;
        chk("abort_post_rd", {31'd0, mem_rdreq}, 32'd0);
        chk("abort_post_wr", {31'd0, mem_wrreq}, 32'd0);
        push(0, 0, 32'h700, 32'h0);
        push(1, 0, 32'h800, 32'h0);
        await_grant(t, w);
        burst(t, 1, 0, 1);
        d_rdreq = 0;
        await_grant(t, w);
        burst(t, 1, 0, 1);
        i_rdreq = 0;
        @(negedge clk);

        // Stray mem_valid in IDLE, then a gapped 3-beat burst.
        mem_valid = 1; mem_out = 32'h5a5a;
        #1;
        chk("idle_d_valid", {31'd0, d_valid}, 32'd0);
        chk("idle_i_valid", {31'd0, i_valid}, 32'd0);
        chk("idle_done", {31'd0, d_done | i_done}, 32'd0);
        @(negedge clk);
        mem_valid = 0; mem_burstlen = 16'd3; i_addr = 32'h900; i_rdreq = 1;
        push(1, 0, 32'h900, 32'h0);
        await_grant(t, w);
        burst(t, 3, 2, 1);
        i_rdreq = 0;
        #1;
        chk("gap_done_state", {31'd0, mem_rdreq}, 32'd0);
        @(negedge clk);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATABITS, default 32, data word width.
REQ-002 SHALL have parameter ADDRBITS, default 32, byte address width.
REQ-003 SHALL have parameter BURSTBITS, default 16, burst-length and beat-counter width.
REQ-004 SHALL have ports, one per line (name  direction  width  meaning):
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- d_addr  in  ADDRBITS  dcache request address.
- d_in  in  DATABITS  dcache write data.
- d_out  out  DATABITS  read data to dcache.
- d_valid  out  1  beat strobe to dcache.
- d_burstlen  out  BURSTBITS  burst length to dcache.
- d_rdreq / d_wrreq  in  1 each  dcache read/write request.
- d_done  out  1  dcache last-beat pulse.
- i_addr, i_in, i_out, i_valid, i_burstlen, i_rdreq, i_wrreq, i_done  —  same directions and widths  —  icache port.
- mem_addr  out  ADDRBITS  memory address.
- mem_in  out  DATABITS  memory write data.
- mem_out  in  DATABITS  memory read data.
- mem_valid  in  1  memory beat strobe.
- mem_burstlen  in  BURSTBITS  memory burst length.
- mem_rdreq / mem_wrreq  out  1 each  memory requests.

Function
REQ-005 SHALL use FSM states IDLE, BUSY, DONE.
REQ-006 IDLE: a client is pending if rdreq|wrreq is high; on the next edge the FSM SHALL latch grant and direction and enter BUSY, so mem_rdreq/mem_wrreq rise 1 cycle after the client request.
REQ-007 Both clients pending in IDLE: grant SHALL go to the client not granted last (round-robin); the first grant after reset SHALL go to dcache.
REQ-008 A client with rdreq and wrreq both high SHALL be served as a write; the read is served in a later transaction.
REQ-009 In BUSY, mem_addr and mem_in SHALL combinationally follow the granted client's addr and in, and exactly one of mem_rdreq/mem_wrreq SHALL be high.
REQ-010 In BUSY, the granted client's valid SHALL equal mem_valid and its out SHALL equal mem_out.
REQ-011 The non-granted client's valid and done SHALL be 0.
REQ-012 d_burstlen and i_burstlen SHALL always equal mem_burstlen.
REQ-013 BURSTBITS beat counter: cleared on entry to BUSY; incremented on each mem_valid.
REQ-014 Last beat: count==mem_burstlen-1, or mem_burstlen==0 (treated as 1). On the last beat the granted client's done SHALL pulse high for that cycle, with valid.
REQ-015 The FSM SHALL go BUSY->DONE on the edge after the last beat. In DONE, mem_rdreq=mem_wrreq=0 for exactly 1 cycle, then IDLE.
REQ-016 Clients SHALL drop requests on done. A request still high in IDLE is a new transaction.
REQ-017 mem_burstlen SHALL be sampled live; the arbiter does not latch it.
REQ-018 Client request changes during BUSY SHALL NOT alter grant or direction.
REQ-019 mem_valid outside BUSY SHALL be ignored: no client valid/done, counter unchanged.

Reset
REQ-020 While reset is high: FSM=IDLE, counter=0, last-grant=icache (so dcache wins first).
REQ-021 While reset is high all outputs SHALL be 0 except *_burstlen, which tracks mem_burstlen.
REQ-022 Reset during BUSY SHALL abort the burst: mem requests low on the cycle after reset is sampled, no done pulse.

Structure
REQ-023 FSM state encodings and grant IDs (GNT_D=0, GNT_I=1) SHALL live in a shared package with the cache-side constants.
REQ-024 Single flat module, no sub-modules.

Verification
REQ-025 dcache read, mem_burstlen=4, mem_valid on 4 consecutive cycles -> mem_rdreq high 1 cycle after d_rdreq; 4 d_valid beats; d_done on beat 4; mem_rdreq low the following cycle.
REQ-026 d_rdreq and i_rdreq rise together, repeated twice -> grants in order dcache, icache, dcache, icache; i_valid stays 0 during dcache bursts.
REQ-027 d_wrreq=d_rdreq=1, burstlen=2 -> mem_wrreq (not rdreq) with mem_in=d_in; after done and DONE cycle, read transaction follows.
REQ-028 mem_burstlen=0, single mem_valid -> done on that beat; FSM back to IDLE after 2 cycles.
REQ-029 reset asserted after beat 2 of 8 -> no done; all mem requests 0 next cycle; next grant goes to dcache.
REQ-030 mem_valid pulsed in IDLE, with gaps mid-burst (burstlen=3, beats spaced 2 idle cycles) -> no spurious valid in IDLE; done only on 3rd beat.
